// File: rtl/key_repeat_pkg.sv
// rtl/key_repeat_pkg.sv - shared state type and timing constants for key_repeat.
// Optional build macro KEY_REPEAT_ACCEL_EN uses ACCEL_AFTER.
package key_repeat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  localparam int DEFAULT_DELAY_CYC = 25_000_000;
  localparam int DEFAULT_RATE_CYC  = 5_000_000;
  localparam int ACCEL_AFTER       = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_repeat_ch.sv
// rtl/key_repeat_ch.sv - one key channel: IDLE/DELAY/REPEAT FSM with its cycle counter.
// Build macro KEY_REPEAT_ACCEL_EN halves the repeat period after ACCEL_AFTER repeats.
module key_repeat_ch
  import key_repeat_pkg::*;
#(
  parameter int DELAY_CYC = DEFAULT_DELAY_CYC,
  parameter int RATE_CYC  = DEFAULT_RATE_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lvl_i,
  input  logic rise_i,
  input  logic repeat_en_i,
  output logic pulse_o,
  output logic repeating_o
);

  localparam int CW = $clog2(max_int(DELAY_CYC, RATE_CYC));
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(RATE_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] period_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    // Release wins over any expiry in the same cycle.
    if (!lvl_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_i) begin
            pulse_d = 1'b1;
            state_d = DELAY;
            cnt_d   = '0;
          end
        end
        DELAY: begin
          if (repeat_en_i) begin
            if (cnt_q == DELAY_LAST) begin
              pulse_d = 1'b1;
              cnt_d   = '0;
              state_d = REPEAT;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        REPEAT: begin
          if (cnt_q == period_last) begin
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_ACCEL_EN
  localparam int AW = $clog2(ACCEL_AFTER + 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(max_int(RATE_CYC / 2, 1) - 1);

  logic [AW-1:0] acc_q, acc_d;
  logic          accel;

  assign accel       = (acc_q == AW'(ACCEL_AFTER));
  assign period_last = accel ? FAST_LAST : RATE_LAST;

  // Counts every auto-repeat pulse, including the one leaving DELAY.
  always_comb begin
    acc_d = acc_q;
    if (!lvl_i) begin
      acc_d = '0;
    end else if (pulse_d && (state_q != IDLE) && !accel) begin
      acc_d = acc_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign period_last = RATE_LAST;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o     = pulse_q;
  assign repeating_o = (state_q == REPEAT);

endmodule

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - key auto-repeat top: edge register plus N_KEYS independent channels.
// Build macro KEY_REPEAT_ACCEL_EN enables repeat acceleration inside each channel.
module key_repeat
  import key_repeat_pkg::*;
#(
  parameter int                N_KEYS      = 5,
  parameter int                DELAY_CYC   = DEFAULT_DELAY_CYC,
  parameter int                RATE_CYC    = DEFAULT_RATE_CYC,
  parameter logic [N_KEYS-1:0] REPEAT_MASK = N_KEYS'(5'b00011)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY_LVL,
  output logic [N_KEYS-1:0] KEY_PULSE,
  output logic [N_KEYS-1:0] REPEATING
);

  if (DELAY_CYC < 2 || RATE_CYC < 2) begin : g_bad_timing
    $error("key_repeat: DELAY_CYC and RATE_CYC must both be at least 2");
  end

  logic [N_KEYS-1:0] lvl_q;
  logic [N_KEYS-1:0] rise;

  // Resetting to ones keeps a key held through reset from firing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lvl_q <= '1;
    end else begin
      lvl_q <= KEY_LVL;
    end
  end

  assign rise = KEY_LVL & ~lvl_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_repeat_ch #(
      .DELAY_CYC (DELAY_CYC),
      .RATE_CYC  (RATE_CYC)
    ) u_ch (
      .clk_i       (CLK),
      .rst_i       (RST),
      .lvl_i       (KEY_LVL[i]),
      .rise_i      (rise[i]),
      .repeat_en_i (REPEAT_MASK[i]),
      .pulse_o     (KEY_PULSE[i]),
      .repeating_o (REPEATING[i])
    );
  end

endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 SHALL have parameter N_KEYS, default 5: number of key channels.
REQ-002 SHALL have parameter DELAY_CYC, default 25_000_000: hold time in cycles before the first repeat (0.5 s at 50 MHz).
REQ-003 SHALL have parameter RATE_CYC, default 5_000_000: cycles between repeats (10 Hz).
REQ-004 SHALL have parameter REPEAT_MASK, default 5'b00011: bit i set means key i auto-repeats (inc/dec); clear means single-shot (select keys).
REQ-005 SHALL have port CLK, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port KEY_LVL, input, N_KEYS bits: debounced key levels from the debouncer, 1 = pressed, synchronous to CLK.
REQ-008 SHALL have port KEY_PULSE, output, N_KEYS bits: one-cycle press/repeat pulses to the digit-entry stage.
REQ-009 SHALL have port REPEATING, output, N_KEYS bits: 1 while channel i is in REPEAT state.

Function
REQ-010 Each channel SHALL run an independent FSM with states IDLE, DELAY, REPEAT and its own cycle counter.
REQ-011 IDLE: on a registered rising edge of KEY_LVL[i], KEY_PULSE[i] SHALL be 1 for exactly one cycle, 1 cycle after KEY_LVL[i] rises. A repeat channel then enters DELAY with the counter cleared; a single-shot channel enters DELAY and never leaves it until release.
REQ-012 DELAY (repeat channel): when the counter reaches DELAY_CYC-1, SHALL pulse once, clear the counter and enter REPEAT. The first repeat pulse is exactly DELAY_CYC cycles after the press pulse.
REQ-013 REPEAT: SHALL pulse every RATE_CYC cycles while KEY_LVL[i]=1.
REQ-014 KEY_LVL[i]=0 in any state SHALL return the channel to IDLE on the next edge, clear the counter, and emit no pulse that cycle, even if the counter would have expired that same cycle.
REQ-015 Release and re-press on consecutive cycles SHALL be treated as a new press (new press pulse, DELAY restarts).
REQ-016 Simultaneous keys SHALL be independent; several KEY_PULSE bits may be 1 in the same cycle.
REQ-017 Counters SHALL be $clog2(max(DELAY_CYC,RATE_CYC)) bits wide, SHALL never wrap, and SHALL saturate/hold in single-shot DELAY.
REQ-018 Parameters with DELAY_CYC<2 or RATE_CYC<2 SHALL be rejected at elaboration.

Reset
REQ-019 While RST=1: KEY_PULSE=0, REPEATING=0, all channels IDLE, all counters 0.
REQ-020 The edge-detect register SHALL reset to all ones, so a key held through reset release produces no pulse until it is released and pressed again.
REQ-021 RST asserted mid-DELAY or mid-REPEAT SHALL abort immediately; no pulse is generated on the reset edge.

Configuration
REQ-022 Macro KEY_REPEAT_ACCEL_EN: when defined, after 8 consecutive repeat pulses on a channel its period SHALL become max(RATE_CYC/2,1) until release; the acceleration count SHALL clear on release or reset.
REQ-023 When KEY_REPEAT_ACCEL_EN is undefined, the period SHALL stay at RATE_CYC for the entire hold, and no acceleration counter SHALL be built.

Structure
REQ-024 Package key_repeat_pkg SHALL hold the state enum (IDLE/DELAY/REPEAT), the default DELAY_CYC/RATE_CYC constants and the ACCEL_AFTER=8 constant.
REQ-025 The per-channel FSM plus counter SHALL be sub-module key_repeat_ch, instantiated N_KEYS times by a generate loop; the top holds only the edge register and the mask fan-out.

Verification (DELAY_CYC=10, RATE_CYC=4, N_KEYS=5)
REQ-026 Press key0 for 30 cycles from cycle 0 -> pulses at cycles 1, 11, 15, 19, 23, 27; REPEATING[0]=1 from cycle 11 until 1 cycle after release.
REQ-027 Press key3 (single-shot) for 30 cycles -> exactly one pulse at cycle 1; REPEATING[3] stays 0.
REQ-028 Press key0 and key1 together, release key1 at cycle 13 -> both pulse at 1 and 11; key0 continues 15, 19, ...; key1 has no pulse after 11.
REQ-029 Release key0 on the cycle its counter would expire (cycle 10) -> no pulse at 11; channel IDLE.
REQ-030 Hold key0 across RST deassert -> no pulse; release then re-press -> pulse 1 cycle after the re-press.
REQ-031 With KEY_REPEAT_ACCEL_EN defined, hold key0 for 60 cycles -> 8 repeats at period 4 starting at cycle 11, then period 2.
